// File: rtl/debug_pkg.sv
// Shared constants, state types and checksum helper for the debug UART transmitter.
package debug_pkg;

    localparam logic [7:0] DBG_SYNC_BYTE = 8'hA5;
    localparam int         DBG_NUM_PORTS = 7;
    localparam int         DBG_PKT_BYTES = 9;

    typedef enum logic {
        DBG_IDLE = 1'b0,
        DBG_SEND = 1'b1
    } dbg_state_t;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    function automatic logic [7:0] dbg_checksum(input logic [DBG_NUM_PORTS-1:0][7:0] ports);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < DBG_NUM_PORTS; i++) begin
            acc = acc ^ ports[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/debug_uart_tx_byte.sv
// 8N1 byte serializer. A start request during the last stop-bit cycle chains
// the next byte with no idle gap; done_o pulses the cycle after each stop bit.
//
// state     | meaning
// SER_IDLE  | line high, waiting for start_i
// SER_START | driving start bit (0)
// SER_DATA  | driving data bits 0..7, LSB first
// SER_STOP  | driving stop bit (1); may reload for the next byte
module uart_tx_byte
    import debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_t       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             tx_q;
    logic             done_q;
    logic             bit_end;

    assign bit_end = (baud_cnt == CNT_LAST);
    assign tx_o    = tx_q;
    assign busy_o  = (state != SER_IDLE);
    assign done_o  = done_q;

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state     <= SER_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                SER_IDLE: begin
                    if (start_i) begin
                        state     <= SER_START;
                        shift_reg <= data_i;
                        tx_q      <= 1'b0;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SER_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        tx_q     <= shift_reg[0];
                        state    <= SER_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                SER_DATA: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            tx_q  <= 1'b1;
                            state <= SER_STOP;
                        end else begin
                            tx_q    <= shift_reg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                SER_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        done_q   <= 1'b1;
                        if (start_i) begin
                            state     <= SER_START;
                            shift_reg <= data_i;
                            tx_q      <= 1'b0;
                            bit_cnt   <= '0;
                        end else begin
                            state <= SER_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= SER_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/debug_uart_tx.sv
// Snapshots seven debug bytes on a trigger and sends sync + data + XOR checksum as 8N1.
//
// state    | meaning
// DBG_IDLE | no packet in flight
// DBG_SEND | feeding packet bytes 0..8 to the serializer
module debug_uart_tx
    import debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = DBG_SYNC_BYTE
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       trigger_i,
    input  logic [7:0] debug1_i,
    input  logic [7:0] debug2_i,
    input  logic [7:0] debug3_i,
    input  logic [7:0] debug4_i,
    input  logic [7:0] debug5_i,
    input  logic [7:0] debug6_i,
    input  logic [7:0] debug7_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int IDX_W = $clog2(DBG_PKT_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DBG_PKT_BYTES - 1);

    dbg_state_t                     state;
    logic [IDX_W-1:0]               byte_idx;
    logic [IDX_W-1:0]               next_idx;
    logic [DBG_NUM_PORTS-1:0][7:0]  ports;
    logic [DBG_NUM_PORTS-1:0][7:0]  snap;
    logic [7:0]                     checksum;
    logic [7:0]                     next_byte;
    logic                           accept;
    logic                           ser_start;
    logic [7:0]                     ser_data;
    logic                           ser_tx;
    logic                           ser_busy;
    logic                           ser_done;

    assign ports    = {debug7_i, debug6_i, debug5_i, debug4_i, debug3_i, debug2_i, debug1_i};
    assign accept   = trigger_i && !ser_busy;
    assign next_idx = byte_idx + 1'b1;

    // The serializer loads byte idx+1 at the end of byte idx, so the mux looks one ahead.
    always_comb begin
        next_byte = SYNC_BYTE;
        if (next_idx == IDX_LAST) begin
            next_byte = checksum;
        end else begin
            for (int i = 0; i < DBG_NUM_PORTS; i++) begin
                if (next_idx == IDX_W'(i + 1)) begin
                    next_byte = snap[i];
                end
            end
        end
    end

    assign ser_start = accept || ((state == DBG_SEND) && (byte_idx != IDX_LAST));
    assign ser_data  = accept ? SYNC_BYTE : next_byte;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .start_i (ser_start),
        .data_i  (ser_data),
        .tx_o    (ser_tx),
        .busy_o  (ser_busy),
        .done_o  (ser_done)
    );

    always_ff @(posedge clk_i) begin
        if (!nreset_i) begin
            state    <= DBG_IDLE;
            byte_idx <= '0;
            snap     <= '0;
            checksum <= '0;
        end else if (accept) begin
            state    <= DBG_SEND;
            byte_idx <= '0;
            snap     <= ports;
            checksum <= dbg_checksum(ports);
        end else if ((state == DBG_SEND) && ser_done) begin
            if (byte_idx == IDX_LAST) begin
                state    <= DBG_IDLE;
                byte_idx <= '0;
            end else begin
                byte_idx <= next_idx;
            end
        end
    end

    assign tx_o   = ser_tx;
    assign busy_o = ser_busy;
    assign done_o = (state == DBG_SEND) && ser_done && (byte_idx == IDX_LAST);

endmodule

// File: tb/tb_debug_uart_tx.sv
// Randomised bench for debug_uart_tx: per-cycle check against a line-level model plus decoded-packet literals.
module tb_debug_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       nreset;
    logic       trigger;
    logic [7:0] dbg [7];
    logic       tx, busy, done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    debug_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
        .clk_i    (clk),
        .nreset_i (nreset),
        .trigger_i(trigger),
        .debug1_i (dbg[0]),
        .debug2_i (dbg[1]),
        .debug3_i (dbg[2]),
        .debug4_i (dbg[3]),
        .debug5_i (dbg[4]),
        .debug6_i (dbg[5]),
        .debug7_i (dbg[6]),
        .tx_o     (tx),
        .busy_o   (busy),
        .done_o   (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: the whole packet becomes a queue of line levels, one per cycle.
    bit         mq[$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    bit         chk_en = 1'b0;
    logic [7:0] m_pkt [9];

    always @(posedge clk) begin
        if (!nreset) begin
            mq.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            chk_en = 1'b1;
        end else begin
            if (trigger && !m_busy) begin
                m_pkt[0] = 8'hA5;
                m_pkt[8] = 8'h00;
                for (int i = 1; i <= 7; i++) begin
                    m_pkt[i] = dbg[i-1];
                    m_pkt[8] = m_pkt[8] ^ dbg[i-1];
                end
                for (int b = 0; b < 9; b++) begin
                    for (int k = 0; k < 10; k++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (k == 0)      mq.push_back(1'b0);
                            else if (k == 9) mq.push_back(1'b1);
                            else             mq.push_back(m_pkt[b][k-1]);
                        end
                    end
                end
            end
            if (mq.size() > 0) begin
                m_tx   = mq.pop_front();
                m_busy = 1'b1;
                m_done = 1'b0;
            end else begin
                m_done = m_busy;
                m_busy = 1'b0;
                m_tx   = 1'b1;
            end
        end
    end

    int done_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", tx, m_tx);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    // Line decoder sampling at bit centres.
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    bit         rx_active = 1'b0;
    int         rx_cnt    = 0;

    always @(negedge clk) begin
        if (busy !== 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt < 38 && (rx_cnt % CPB) == 2) rx_byte[rx_cnt/CPB - 1] = tx;
            if (rx_cnt == 38) begin
                rx_q.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int max_cyc, output int done_at);
        done_at = -1;
        for (int i = 0; i < max_cyc; i++) begin
            tick(1);
            if (done === 1'b1) begin
                done_at = cyc;
                break;
            end
        end
        if (done_at < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout cyc=%0d actual=none required=done_pulse", cyc);
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    task automatic check_packet(input string name, input logic [7:0] exp [9]);
        check({name, "_nbytes"}, rx_q.size(), 9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), rx_q[i], exp[i]);
        end
    endtask

    int         t0, d1, d2, toggles;
    logic       prev_tx;
    logic [7:0] lit [9];
    logic [7:0] exp_pkt [9];

    initial begin
        nreset  = 1'b0;
        trigger = 1'b0;
        for (int i = 0; i < 7; i++) dbg[i] = 8'h00;
        tick(3);
        nreset = 1'b1;
        tick(1);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        toggles = 0;
        for (int i = 0; i < 100; i++) begin
            prev_tx = tx;
            tick(1);
            if (tx !== prev_tx) toggles++;
        end
        check("idle_toggles", toggles, 0);

        // Single packet with snapshot isolation and a trigger while busy.
        dbg[0] = 8'h80; dbg[1] = 8'h01; dbg[2] = 8'hFF; dbg[3] = 8'h00;
        dbg[4] = 8'h3C; dbg[5] = 8'hC3; dbg[6] = 8'h55;
        lit[0] = 8'hA5; lit[1] = 8'h80; lit[2] = 8'h01; lit[3] = 8'hFF; lit[4] = 8'h00;
        lit[5] = 8'h3C; lit[6] = 8'hC3; lit[7] = 8'h55; lit[8] = 8'hD4;
        rx_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        t0 = cyc;
        pulse_trigger();
        tick(4);
        for (int i = 0; i < 7; i++) dbg[i] = 8'h00;
        tick(t0 + 100 - cyc);
        pulse_trigger();
        wait_done(600, d1);
        check("done_cycle", d1, t0 + 361);
        tick(20);
        check("single_done_cnt", done_cnt, 1);
        check("single_busy_cycles", busy_cnt, 360);
        check_packet("single", lit);

        // Randomised packets, some retriggered in the done cycle.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 7; i++) dbg[i] = 8'($urandom);
            tick($urandom_range(0, 10));
            pulse_trigger();
            tick($urandom_range(1, 300));
            for (int i = 0; i < 7; i++) dbg[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) pulse_trigger();
            wait_done(500, d1);
            if ($urandom_range(0, 1) == 1) begin
                trigger = 1'b1;
                tick(1);
                trigger = 1'b0;
                wait_done(500, d1);
            end
        end
        tick(10);

        // Back-to-back with trigger held high.
        for (int i = 0; i < 7; i++) dbg[i] = 8'($urandom);
        rx_q.delete();
        done_cnt = 0;
        trigger = 1'b1;
        wait_done(500, d1);
        wait_done(500, d2);
        trigger = 1'b0;
        check("b2b_spacing", d2 - d1, 361);
        tick(10);
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_nbytes", rx_q.size(), 18);

        // Reset mid-packet, then a full packet.
        done_cnt = 0;
        t0 = cyc;
        pulse_trigger();
        tick(t0 + 150 - cyc);
        nreset = 1'b0;
        tick(1);
        nreset = 1'b1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        tick(400);
        check("midrst_done_cnt", done_cnt, 0);
        rx_q.delete();
        exp_pkt[0] = 8'hA5;
        exp_pkt[8] = 8'h00;
        for (int i = 0; i < 7; i++) begin
            dbg[i]       = 8'($urandom);
            exp_pkt[i+1] = dbg[i];
            exp_pkt[8]   = exp_pkt[8] ^ dbg[i];
        end
        pulse_trigger();
        wait_done(500, d1);
        tick(5);
        check("after_rst_done_cnt", done_cnt, 1);
        check_packet("after_rst", exp_pkt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

endmodule
